// File: rtl/serial_parity_pkg.sv
// Shared types and width helpers for the serial parity word generator.
package serial_parity_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Width needed to count 0..data_w inclusive.
    function automatic int len_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_parity_gen.sv
// Deserializes a qualified MSB-first bit stream into words and presents each
// word with its parity on a registered valid/ready output port.
module serial_parity_gen
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int LEN_W      = len_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              data_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_parity,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(DATA_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                par_q, par_d;
    logic                flush_pend_q, flush_pend_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [LEN_W-1:0]    out_len_q, out_len_d;
    logic                out_parity_q, out_parity_d;
    logic                overrun_q, overrun_d;

    logic                out_free;
    logic                load;
    logic [DATA_W-1:0]   load_data;
    logic [LEN_W-1:0]    load_len;
    logic                load_par;
    logic [DATA_W-1:0]   acc_n;
    logic [LEN_W-1:0]    cnt_n;
    logic                par_n;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_len_d    = out_len_q;
        out_parity_d = out_parity_q;
        overrun_d    = overrun_q;
        load         = 1'b0;
        load_data    = acc_q;
        load_len     = cnt_q;
        load_par     = par_q;
        acc_n        = acc_q;
        cnt_n        = cnt_q;
        par_n        = par_q;

        out_free = !out_valid_q || out_ready;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (clr_overrun) overrun_d = 1'b0;

        unique case (state_q)
            COLLECT: begin
                // The incoming bit is appended before any flush decision.
                if (wr_en) begin
                    acc_n = {acc_q[DATA_W-2:0], data_in};
                    cnt_n = cnt_q + LEN_W'(1);
                    par_n = par_q ^ data_in;
                end
                if (cnt_n == FULL_CNT || ((flush || flush_pend_q) && cnt_n != '0)) begin
                    if (out_free) begin
                        load         = 1'b1;
                        load_data    = acc_n;
                        load_len     = cnt_n;
                        load_par     = par_n;
                        acc_d        = '0;
                        cnt_d        = '0;
                        par_d        = 1'b0;
                        flush_pend_d = 1'b0;
                    end else begin
                        acc_d        = acc_n;
                        cnt_d        = cnt_n;
                        par_d        = par_n;
                        flush_pend_d = (cnt_n != FULL_CNT);
                        if (cnt_n == FULL_CNT) state_d = HOLD;
                    end
                end else begin
                    acc_d        = acc_n;
                    cnt_d        = cnt_n;
                    par_d        = par_n;
                    flush_pend_d = 1'b0;
                end
            end
            HOLD: begin
                // Set wins over a same-cycle clear.
                if (wr_en) overrun_d = 1'b1;
                if (out_free) begin
                    load         = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                    par_d        = 1'b0;
                    flush_pend_d = 1'b0;
                    state_d      = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = load_data;
            out_len_d    = load_len;
            out_parity_d = load_par ^ ODD_PARITY;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            acc_q        <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_len_q    <= '0;
            out_parity_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_len_q    <= out_len_d;
            out_parity_q <= out_parity_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_len    = out_len_q;
    assign out_parity = out_parity_q;
    assign overrun    = overrun_q;

endmodule
